multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack_i before faulting (range 1..255).
REQ-002 SHALL have port clk_i  input  1  single clock, all state updated on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start_i  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port stop_i  input  1  return to IDLE at the next instruction boundary.
REQ-006 SHALL have port opcode_i  input  7  opcode bits [6:0] from the instruction register.
REQ-007 SHALL have port zero_i  input  1  ALU zero flag.
REQ-008 SHALL have port mem_ack_i  input  1  memory transfer complete.
REQ-009 SHALL have port mem_req_o  output  1  memory request.
REQ-010 SHALL have port mem_read_o / mem_write_o  output  1 each  transfer direction, valid with mem_req_o.
REQ-011 SHALL have port ir_write_o / pc_write_o / reg_write_o  output  1 each  write strobes.
REQ-012 SHALL have port imm_sel_o  output  2  immediate-generator format: 00 none, 01 I (I-type/ld), 10 S (sd), 11 B (beq).
REQ-013 SHALL have port alu_src_b_o  output  1  0 = register, 1 = immediate.
REQ-014 SHALL have port alu_op_o  output  2  00 ADD, 01 SUB, 10 FUNCT (ALU control decodes funct fields).
REQ-015 SHALL have port mem_to_reg_o  output  1  writeback source is memory data.
REQ-016 SHALL have ports busy_o, illegal_o, timeout_o  output  1 each  status flags.
REQ-017 SHALL have port retired_o  output  32  retired-instruction count.

Function
REQ-018 SHALL implement the states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH and FAULT, held in a registered state with all outputs decoded from state and inputs (Moore plus ack/zero gating).
REQ-019 SHALL transition IDLE->FETCH when start_i=1; busy_o=1 in every state except IDLE and FAULT.
REQ-020 FETCH SHALL assert mem_req_o and mem_read_o; on the mem_ack_i=1 cycle, ir_write_o=1 and pc_write_o=1 (PC+4); next state DECODE.
REQ-021 DECODE SHALL branch on opcode_i: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->ADDR, 1100011->BRANCH; any other opcode->FAULT with illegal_o set.
REQ-022 imm_sel_o SHALL be driven from opcode_i in DECODE, EXEC_I, ADDR, MEM_RD, MEM_WR and BRANCH, and SHALL be 00 in all other states.
REQ-023 EXEC_R: alu_src_b_o=0, alu_op_o=FUNCT. EXEC_I: alu_src_b_o=1, alu_op_o=FUNCT. Both -> WB_ALU.
REQ-024 ADDR: alu_src_b_o=1, alu_op_o=ADD; ld->MEM_RD, sd->MEM_WR.
REQ-025 MEM_RD/MEM_WR SHALL hold mem_req_o with the matching direction until mem_ack_i=1; MEM_RD->WB_MEM; MEM_WR completes the instruction.
REQ-026 WB_ALU: reg_write_o=1, mem_to_reg_o=0. WB_MEM: reg_write_o=1, mem_to_reg_o=1. Both complete the instruction.
REQ-027 BRANCH: alu_src_b_o=0, alu_op_o=SUB, pc_write_o=zero_i (target taken when equal); completes the instruction.
REQ-028 On completion, retired_o SHALL increment by 1 (wrapping 0xFFFFFFFF->0); next state IDLE if stop_i=1 in that cycle, else FETCH.
REQ-029 Latency with a zero-wait memory (ack in the first request cycle) SHALL be: beq 3 cycles; R-type, I-type and sd 4 cycles; ld 5 cycles.
REQ-030 A wait counter SHALL restart on every entry into FETCH/MEM_RD/MEM_WR; if MEM_TIMEOUT cycles elapse without ack, next state is FAULT with timeout_o set.
REQ-031 mem_ack_i SHALL be ignored outside request states, and stop_i and start_i outside their sampling states.
REQ-032 FAULT SHALL be absorbing: all strobes 0, busy_o=0, and illegal_o/timeout_o sticky until reset.

Reset
REQ-033 With rst_i=0 at a clock edge: state=IDLE, all outputs 0, retired_o=0, flags cleared, wait counter 0.
REQ-034 Reset asserted mid-instruction SHALL abort with no write strobe in the following cycle; there is no partial retire.

Structure
REQ-035 A shared package SHALL hold the state enum, the opcode constants, and the imm_sel and alu_op encodings; the immediate generator imports the same imm_sel encoding.
REQ-036 The wait/timeout counter SHALL be one sub-module, mem_wait_timer (start, tick, expired).

Verification
REQ-037 Reset, start_i=1, ack always 1, R-type opcode 0110011 -> FETCH,DECODE,EXEC_R,WB_ALU; reg_write_o high in cycle 4; retired_o=1.
REQ-038 ld 0000011 with ack delayed 3 cycles in MEM_RD -> mem_req_o held 3 cycles, then ack; WB_MEM with mem_to_reg_o=1; imm_sel_o=01 in ADDR.
REQ-039 beq 1100011 with zero_i=1, then zero_i=0 -> pc_write_o=1 in the first BRANCH and 0 in the second; imm_sel_o=11; 3 cycles each.
REQ-040 opcode 1111111 -> FAULT after DECODE, illegal_o=1, busy_o=0; start_i is ignored until rst_i=0.
REQ-041 MEM_TIMEOUT=4, ack never asserted in FETCH -> FAULT after 4 FETCH cycles, timeout_o=1.
REQ-042 stop_i=1 during the final cycle of an sd -> IDLE next cycle; rst_i=0 during EXEC_R -> no reg_write_o, and retired_o unchanged at 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// immediate-format and ALU-operation codes used by the datapath decoders.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_FAULT
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_S    = 2'b10,
        IMM_B    = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    // Immediate format implied by an opcode; R-type and unknown opcodes carry none.
    function automatic imm_sel_t imm_sel_for(input logic [6:0] opcode);
        imm_sel_t sel;
        case (opcode)
            OP_I, OP_LD: sel = IMM_I;
            OP_SD:       sel = IMM_S;
            OP_BEQ:      sel = IMM_B;
            default:     sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory transfer; expired flags the last
// permitted cycle so the controller can fault instead of waiting further.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + 8'd1;
        end
    end

    // count is the number of cycles already elapsed in the current request
    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction-sequencing FSM: fetch, decode, execute, memory and
// writeback control strobes, with memory-timeout and illegal-opcode faults.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [6:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ack_i,
    output logic        mem_req_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic [1:0]  imm_sel_o,
    output logic        alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        mem_to_reg_o,
    output logic        busy_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [31:0] retired_o
);

    state_t      state;
    logic        illegal_q;
    logic        timeout_q;
    logic [31:0] retired_q;
    logic        req_state;
    logic        wait_expired;

    assign req_state = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    // Clearing on every non-request cycle and on every ack guarantees a fresh
    // count on each entry, including the MEM_WR -> FETCH back-to-back case.
    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (!req_state || mem_ack_i),
        .tick    (req_state && !mem_ack_i),
        .expired (wait_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ack_i) begin
                        state <= ST_DECODE;
                    end else if (wait_expired) begin
                        state     <= ST_FAULT;
                        timeout_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    case (opcode_i)
                        OP_R:        state <= ST_EXEC_R;
                        OP_I:        state <= ST_EXEC_I;
                        OP_LD, OP_SD: state <= ST_ADDR;
                        OP_BEQ:      state <= ST_BRANCH;
                        default: begin
                            state     <= ST_FAULT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I: begin
                    state <= ST_WB_ALU;
                end
                ST_ADDR: begin
                    state <= (opcode_i == OP_LD) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    if (mem_ack_i) begin
                        state <= ST_WB_MEM;
                    end else if (wait_expired) begin
                        state     <= ST_FAULT;
                        timeout_q <= 1'b1;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ack_i) begin
                        retired_q <= retired_q + 32'd1;
                        state     <= stop_i ? ST_IDLE : ST_FETCH;
                    end else if (wait_expired) begin
                        state     <= ST_FAULT;
                        timeout_q <= 1'b1;
                    end
                end
                ST_WB_ALU, ST_WB_MEM, ST_BRANCH: begin
                    retired_q <= retired_q + 32'd1;
                    state     <= stop_i ? ST_IDLE : ST_FETCH;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        imm_sel_o    = IMM_NONE;
        alu_src_b_o  = 1'b0;
        alu_op_o     = ALU_ADD;
        mem_to_reg_o = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req_o  = 1'b1;
                mem_read_o = 1'b1;
                ir_write_o = mem_ack_i;
                pc_write_o = mem_ack_i;
            end
            ST_DECODE: begin
                imm_sel_o = imm_sel_for(opcode_i);
            end
            ST_EXEC_R: begin
                alu_src_b_o = 1'b0;
                alu_op_o    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                imm_sel_o   = imm_sel_for(opcode_i);
                alu_src_b_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            ST_ADDR: begin
                imm_sel_o   = imm_sel_for(opcode_i);
                alu_src_b_o = 1'b1;
                alu_op_o    = ALU_ADD;
            end
            ST_MEM_RD: begin
                imm_sel_o  = imm_sel_for(opcode_i);
                mem_req_o  = 1'b1;
                mem_read_o = 1'b1;
            end
            ST_MEM_WR: begin
                imm_sel_o   = imm_sel_for(opcode_i);
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            ST_WB_ALU: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b0;
            end
            ST_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            ST_BRANCH: begin
                imm_sel_o   = imm_sel_for(opcode_i);
                alu_src_b_o = 1'b0;
                alu_op_o    = ALU_SUB;
                pc_write_o  = zero_i;
            end
            default: begin
            end
        endcase
    end

    assign busy_o    = (state != ST_IDLE) && (state != ST_FAULT);
    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-plan reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_multicycle_control;

    localparam int unsigned TO = 4;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    // Steps of one instruction's plan
    localparam int P_FETCH = 0, P_DECODE = 1, P_EXR = 2, P_EXI = 3, P_ADDR = 4;
    localparam int P_RD = 5, P_WR = 6, P_WBA = 7, P_WBM = 8, P_BR = 9;

    logic        clk = 1'b0;
    logic        rst_i, start_i, stop_i, zero_i, mem_ack_i;
    logic [6:0]  opcode_i;
    logic        mem_req_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]  imm_sel_o, alu_op_o;
    logic        alu_src_b_o, mem_to_reg_o, busy_o, illegal_o, timeout_o;
    logic [31:0] retired_o;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .opcode_i(opcode_i), .zero_i(zero_i), .mem_ack_i(mem_ack_i),
        .mem_req_o(mem_req_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .imm_sel_o(imm_sel_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .mem_to_reg_o(mem_to_reg_o), .busy_o(busy_o), .illegal_o(illegal_o),
        .timeout_o(timeout_o), .retired_o(retired_o)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 running a plan, 2 faulted
    int          m_mode = 0;
    int          plan[$];
    int          m_wait = 0;
    logic        m_ill = 1'b0;
    logic        m_to = 1'b0;
    logic [31:0] m_ret = 32'd0;
    logic [6:0]  ops [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == OPC_I || op == OPC_LD) return 2'b01;
        if (op == OPC_SD)  return 2'b10;
        if (op == OPC_BEQ) return 2'b11;
        return 2'b00;
    endfunction

    task automatic compare();
        logic e_req, e_rd, e_wr, e_ir, e_pc, e_rw, e_m2r, e_srcb;
        logic [1:0] e_imm, e_op;
        int s;
        e_req = 0; e_rd = 0; e_wr = 0; e_ir = 0; e_pc = 0; e_rw = 0; e_m2r = 0; e_srcb = 0;
        e_imm = 2'b00; e_op = 2'b00;
        s = (m_mode == 1) ? plan[0] : -1;
        case (s)
            P_FETCH:  begin e_req = 1; e_rd = 1; e_ir = mem_ack_i; e_pc = mem_ack_i; end
            P_DECODE: e_imm = exp_imm(opcode_i);
            P_EXR:    begin e_srcb = 0; e_op = 2'b10; end
            P_EXI:    begin e_srcb = 1; e_op = 2'b10; e_imm = exp_imm(opcode_i); end
            P_ADDR:   begin e_srcb = 1; e_op = 2'b00; e_imm = exp_imm(opcode_i); end
            P_RD:     begin e_req = 1; e_rd = 1; e_imm = exp_imm(opcode_i); end
            P_WR:     begin e_req = 1; e_wr = 1; e_imm = exp_imm(opcode_i); end
            P_WBA:    e_rw = 1;
            P_WBM:    begin e_rw = 1; e_m2r = 1; end
            P_BR:     begin e_op = 2'b01; e_pc = zero_i; e_imm = exp_imm(opcode_i); end
            default:  ;
        endcase
        chk("mem_req", 32'(mem_req_o), 32'(e_req));
        chk("mem_read", 32'(mem_read_o), 32'(e_rd));
        chk("mem_write", 32'(mem_write_o), 32'(e_wr));
        chk("ir_write", 32'(ir_write_o), 32'(e_ir));
        chk("pc_write", 32'(pc_write_o), 32'(e_pc));
        chk("reg_write", 32'(reg_write_o), 32'(e_rw));
        chk("mem_to_reg", 32'(mem_to_reg_o), 32'(e_m2r));
        chk("alu_src_b", 32'(alu_src_b_o), 32'(e_srcb));
        chk("imm_sel", 32'(imm_sel_o), 32'(e_imm));
        chk("alu_op", 32'(alu_op_o), 32'(e_op));
        chk("busy", 32'(busy_o), 32'(m_mode == 1));
        chk("illegal", 32'(illegal_o), 32'(m_ill));
        chk("timeout", 32'(timeout_o), 32'(m_to));
        chk("retired", retired_o, m_ret);
    endtask

    task automatic go_fault(input logic is_timeout);
        m_mode = 2;
        plan.delete();
        if (is_timeout) m_to = 1'b1;
        else m_ill = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs held at that edge
    task automatic model_update();
        int  s;
        bit  done;
        if (!rst_i) begin
            m_mode = 0; plan.delete(); m_wait = 0;
            m_ill = 1'b0; m_to = 1'b0; m_ret = 32'd0;
            return;
        end
        if (m_mode == 0) begin
            if (start_i) begin
                m_mode = 1; plan = '{P_FETCH, P_DECODE}; m_wait = 0;
            end
            return;
        end
        if (m_mode == 2) return;
        s = plan[0];
        done = 1;
        if ((s == P_FETCH || s == P_RD || s == P_WR) && !mem_ack_i) begin
            done = 0;
            if (m_wait + 1 == int'(TO)) go_fault(1'b1);
            else m_wait++;
        end
        if (done && s == P_DECODE) begin
            if (opcode_i == OPC_R)        plan.push_back(P_EXR);
            else if (opcode_i == OPC_I)   plan.push_back(P_EXI);
            else if (opcode_i == OPC_LD)  begin plan.push_back(P_ADDR); plan.push_back(P_RD); end
            else if (opcode_i == OPC_SD)  begin plan.push_back(P_ADDR); plan.push_back(P_WR); end
            else if (opcode_i == OPC_BEQ) plan.push_back(P_BR);
            else begin done = 0; go_fault(1'b0); end
            if (opcode_i == OPC_R || opcode_i == OPC_I) plan.push_back(P_WBA);
            if (opcode_i == OPC_LD) plan.push_back(P_WBM);
        end
        if (done) begin
            void'(plan.pop_front());
            m_wait = 0;
            if (plan.size() == 0) begin
                m_ret = m_ret + 32'd1;
                if (stop_i) m_mode = 0;
                else plan = '{P_FETCH, P_DECODE};
            end
        end
    endtask

    task automatic sample();
        #1;
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        int fault_age;
        int r;
        ops = '{OPC_R, OPC_I, OPC_LD, OPC_SD, OPC_BEQ};
        rst_i = 0; start_i = 0; stop_i = 0; zero_i = 0; mem_ack_i = 0; opcode_i = OPC_R;
        @(negedge clk);

        // Reset state
        sample();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_retired", retired_o, 32'd0);
        chk("reset_mem_req", 32'(mem_req_o), 32'd0);
        advance();

        // R-type, zero-wait memory, stop after retire
        rst_i = 1; start_i = 1; stop_i = 1; mem_ack_i = 1; opcode_i = OPC_R;
        step();
        start_i = 0;
        sample(); chk("r_fetch_ir_write", 32'(ir_write_o), 32'd1); advance();
        step();
        sample(); chk("r_exec_alu_op", 32'(alu_op_o), 32'd2); advance();
        sample(); chk("r_wb_reg_write", 32'(reg_write_o), 32'd1); advance();
        sample(); chk("r_retired", retired_o, 32'd1); chk("r_idle_busy", 32'(busy_o), 32'd0); advance();

        // ld with ack arriving on the third MEM_RD cycle
        start_i = 1; opcode_i = OPC_LD; mem_ack_i = 1;
        step();
        start_i = 0;
        step();
        mem_ack_i = 0;
        step();
        sample(); chk("ld_addr_imm_sel", 32'(imm_sel_o), 32'd1); advance();
        for (int i = 0; i < 3; i++) begin
            mem_ack_i = (i == 2);
            sample(); chk("ld_mem_req_held", 32'(mem_req_o), 32'd1); advance();
        end
        sample(); chk("ld_wb_mem_to_reg", 32'(mem_to_reg_o), 32'd1); advance();
        sample(); chk("ld_retired", retired_o, 32'd2); advance();

        // Two back-to-back beq: taken then not taken
        start_i = 1; stop_i = 0; opcode_i = OPC_BEQ; mem_ack_i = 1; zero_i = 1;
        step();
        start_i = 0;
        step(); step();
        sample(); chk("beq1_pc_write", 32'(pc_write_o), 32'd1); chk("beq_imm_sel", 32'(imm_sel_o), 32'd3); advance();
        zero_i = 0;
        step(); step();
        stop_i = 1;
        sample(); chk("beq2_pc_write", 32'(pc_write_o), 32'd0); chk("beq2_alu_op", 32'(alu_op_o), 32'd1); advance();
        sample(); chk("beq_retired", retired_o, 32'd4); advance();

        // sd with stop in its final cycle
        start_i = 1; stop_i = 0; opcode_i = OPC_SD;
        step();
        start_i = 0;
        step(); step(); step();
        stop_i = 1;
        sample(); chk("sd_mem_write", 32'(mem_write_o), 32'd1); advance();
        sample(); chk("sd_stop_busy", 32'(busy_o), 32'd0); chk("sd_retired", retired_o, 32'd5); advance();

        // Reset during EXEC_R aborts the instruction
        start_i = 1; opcode_i = OPC_R;
        step();
        start_i = 0;
        step(); step();
        rst_i = 0;
        step();
        rst_i = 1;
        sample(); chk("abort_reg_write", 32'(reg_write_o), 32'd0); chk("abort_retired", retired_o, 32'd0); advance();

        // Fetch timeout after TO cycles without ack
        start_i = 1; mem_ack_i = 0;
        step();
        start_i = 0;
        for (int i = 0; i < int'(TO); i++) begin
            sample(); chk("to_fetch_req", 32'(mem_req_o), 32'd1); advance();
        end
        start_i = 1;
        sample(); chk("to_timeout", 32'(timeout_o), 32'd1); chk("to_busy", 32'(busy_o), 32'd0); advance();
        step(); step();
        rst_i = 0; start_i = 0;
        step();
        rst_i = 1;
        sample(); chk("to_cleared", 32'(timeout_o), 32'd0); advance();

        // Illegal opcode faults and ignores start until reset
        start_i = 1; mem_ack_i = 1; opcode_i = 7'b1111111;
        step();
        start_i = 0;
        step(); step();
        sample(); chk("ill_flag", 32'(illegal_o), 32'd1); chk("ill_busy", 32'(busy_o), 32'd0); advance();
        start_i = 1;
        step(); step();
        sample(); chk("ill_sticky", 32'(illegal_o), 32'd1); chk("ill_start_ignored", 32'(mem_req_o), 32'd0); advance();
        rst_i = 0; start_i = 0;
        step();

        // Randomized traffic
        fault_age = 0;
        for (int n = 0; n < 4000; n++) begin
            rst_i = ($urandom_range(0, 149) != 0);
            if (m_mode == 2 && fault_age > 3) rst_i = 0;
            start_i   = $urandom_range(0, 1);
            stop_i    = ($urandom_range(0, 3) == 0);
            mem_ack_i = ($urandom_range(0, 9) < 7);
            zero_i    = $urandom_range(0, 1);
            if (m_mode != 1 || plan[0] == P_FETCH) begin
                r = $urandom_range(0, 39);
                if (r == 0) opcode_i = 7'($urandom);
                else opcode_i = ops[r % 5];
            end
            step();
            fault_age = (m_mode == 2) ? fault_age + 1 : 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
